// File: rtl/cyclic_prefix_remove_pkg.sv
// Shared definitions for the cyclic-prefix remover: default frame geometry
// (common with the transmitter's guard insertion) and the FSM state encoding.
package cyclic_prefix_remove_pkg;

  localparam int   DEF_FRAME_LEN   = 100;
  localparam int   DEF_PAYLOAD_LEN = 90;
  localparam logic DEF_GUARD_VAL   = 1'b1;
  localparam int   DEF_CNT_W       = 7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_GUARD   = 2'd2
  } cp_state_t;

endpackage

// File: rtl/cyclic_prefix_remove_guard_checker.sv
// Guard-field checker for the cyclic-prefix remover: ORs guard-bit mismatches into a
// flag and pulses guard_err at the end of the field. Only exists when GUARD_CHECK_EN is defined.
`ifdef GUARD_CHECK_EN
module cp_guard_checker
  import cyclic_prefix_remove_pkg::*;
#(
  parameter logic GUARD_VAL = DEF_GUARD_VAL
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bit_in,
  input  logic       enable,
  input  logic       clear,
  input  logic       last,
  output logic       guard_err,
  output logic [7:0] err_cnt
);

  logic flag;
  logic mismatch;
  logic frame_bad;

  assign mismatch  = (bit_in != GUARD_VAL);
  assign frame_bad = flag | mismatch;

  // A re-align aborts the frame, so its partial guard history is simply discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag      <= 1'b0;
      guard_err <= 1'b0;
      err_cnt   <= 8'd0;
    end else begin
      guard_err <= 1'b0;
      if (clear) begin
        flag <= 1'b0;
      end else if (enable) begin
        if (last) begin
          guard_err <= frame_bad;
          flag      <= 1'b0;
          if (frame_bad && (err_cnt != 8'hFF))
            err_cnt <= err_cnt + 8'd1;
        end else begin
          flag <= frame_bad;
        end
      end
    end
  end

endmodule
`endif

// File: rtl/cyclic_prefix_remove.sv
// Receive-side cyclic-prefix/guard removal: forwards payload bits with a strobe and drops
// the guard field. Guard checking (cp_guard_checker) is built only with GUARD_CHECK_EN.
module cyclic_prefix_remove
  import cyclic_prefix_remove_pkg::*;
#(
  parameter int   FRAME_LEN   = DEF_FRAME_LEN,
  parameter int   PAYLOAD_LEN = DEF_PAYLOAD_LEN,
`ifdef GUARD_CHECK_EN
  parameter logic GUARD_VAL   = DEF_GUARD_VAL,
`endif
  parameter int   CNT_W       = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic sync,
  input  logic data_in,
  output logic data_out,
  output logic ready,
  output logic frame_end,
  output logic guard_err
);

  localparam logic [CNT_W-1:0] LAST_PAYLOAD = CNT_W'(PAYLOAD_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_FRAME   = CNT_W'(FRAME_LEN - 1);

  cp_state_t        state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             data_nxt, ready_nxt, frame_end_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      count     <= '0;
      data_out  <= 1'b0;
      ready     <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      data_out  <= data_nxt;
      ready     <= ready_nxt;
      frame_end <= frame_end_nxt;
    end
  end

  // sync wins over the current position in any state; count then points at the next bit.
  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    data_nxt      = data_out;
    ready_nxt     = 1'b0;
    frame_end_nxt = 1'b0;
    if (start) begin
      if (sync) begin
        data_nxt  = data_in;
        ready_nxt = 1'b1;
        count_nxt = CNT_W'(1);
        state_nxt = ST_PAYLOAD;
        if (PAYLOAD_LEN == 1) begin
          frame_end_nxt = 1'b1;
          state_nxt     = ST_GUARD;
        end
      end else begin
        case (state)
          ST_PAYLOAD: begin
            data_nxt  = data_in;
            ready_nxt = 1'b1;
            count_nxt = count + CNT_W'(1);
            if (count == LAST_PAYLOAD) begin
              frame_end_nxt = 1'b1;
              state_nxt     = ST_GUARD;
            end
          end
          ST_GUARD: begin
            if (count == LAST_FRAME) begin
              count_nxt = '0;
              state_nxt = ST_PAYLOAD;
            end else begin
              count_nxt = count + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef GUARD_CHECK_EN
  logic       guard_bit;
  logic       guard_last;
  logic       realign;
  logic [7:0] err_cnt;

  assign realign    = start & sync;
  assign guard_bit  = start & ~sync & (state == ST_GUARD);
  assign guard_last = guard_bit & (count == LAST_FRAME);

  cp_guard_checker #(
    .GUARD_VAL (GUARD_VAL)
  ) u_guard (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_in    (data_in),
    .enable    (guard_bit),
    .clear     (realign),
    .last      (guard_last),
    .guard_err (guard_err),
    .err_cnt   (err_cnt)
  );
`else
  assign guard_err = 1'b0;
`endif

endmodule

// File: tb/tb_cyclic_prefix_remove.sv
// Randomized self-checking bench for cyclic_prefix_remove; a frame-position reference
// model predicts every output cycle. Honours GUARD_CHECK_EN for guard_err/err_cnt.
module tb_cyclic_prefix_remove;

  localparam int   FL = 100;
  localparam int   PL = 90;
  localparam logic GV = 1'b1;

  logic clk = 1'b0;
  logic rst_n;
  logic start, sync, data_in;
  logic data_out, ready, frame_end, guard_err;

  int testsRun    = 0;
  int testsFailed = 0;

  // reference model state: position of the next accepted bit, -1 when unaligned
  int   pos = -1;
  logic mism = 1'b0;
  logic expReady = 1'b0, expData = 1'b0, expFe = 1'b0, expGe = 1'b0;
  int   expErrCnt = 0;

  cyclic_prefix_remove dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sync      (sync),
    .data_in   (data_in),
    .data_out  (data_out),
    .ready     (ready),
    .frame_end (frame_end),
    .guard_err (guard_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    pos = -1; mism = 1'b0;
    expReady = 1'b0; expData = 1'b0; expFe = 1'b0; expGe = 1'b0;
    expErrCnt = 0;
  endtask

  // Predict the outputs seen after the next clock edge from the inputs of this cycle.
  task automatic modelStep(input logic st, input logic sy, input logic d);
    expReady = 1'b0; expFe = 1'b0; expGe = 1'b0;
    if (st) begin
      if (sy) begin pos = 0; mism = 1'b0; end
      if (pos >= 0) begin
        if (pos < PL) begin
          expReady = 1'b1;
          expData  = d;
          expFe    = (pos == PL - 1);
        end else begin
          if (d != GV) mism = 1'b1;
          if (pos == FL - 1) begin
`ifdef GUARD_CHECK_EN
            expGe = mism;
`endif
            mism = 1'b0;
          end
        end
        pos = (pos + 1) % FL;
      end
    end
    if (expGe && expErrCnt < 255) expErrCnt++;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".ready"},     32'(ready),     32'(expReady));
    checkOutput({tag, ".data_out"},  32'(data_out),  32'(expData));
    checkOutput({tag, ".frame_end"}, 32'(frame_end), 32'(expFe));
    checkOutput({tag, ".guard_err"}, 32'(guard_err), 32'(expGe));
  endtask

  task automatic applyStimulus(input logic st, input logic sy, input logic d);
    @(negedge clk);
    start = st; sync = sy; data_in = d;
    modelStep(st, sy, d);
    @(posedge clk);
    #1;
    checkAll("cycle");
  endtask

  // Send nBits of a frame starting at bit 0; corruptPos flips that guard bit.
  task automatic sendFrame(input logic withSync, input int corruptPos, input int nBits);
    for (int i = 0; i < nBits; i++) begin
      logic d;
      if (i < PL) d = 1'($urandom % 2);
      else        d = (i == corruptPos) ? ~GV : GV;
      applyStimulus(1'b1, withSync && (i == 0), d);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sync = 1'b0; data_in = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // bits before any sync are ignored
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'($urandom % 2));

    // single aligned frame, then two free-running frames
    sendFrame(1'b1, -1, FL);
    sendFrame(1'b0, -1, FL);
    sendFrame(1'b0, -1, FL);

    // start toggling; sync with start=0 must be ignored
    for (int i = 0; i < FL; i++) begin
      applyStimulus(1'b1, 1'b0, (i < PL) ? 1'($urandom % 2) : GV);
      applyStimulus(1'b0, 1'($urandom % 2), 1'($urandom % 2));
    end

    // corrupted guard bit 95, then a clean frame
    sendFrame(1'b0, 95, FL);
    sendFrame(1'b0, -1, FL);

    // re-align at payload bit 40, and an abort inside a corrupted guard field
    sendFrame(1'b0, -1, 40);
    sendFrame(1'b1, -1, FL);
    sendFrame(1'b0, 92, 95);
    sendFrame(1'b1, -1, FL);

    // reset at payload bit 50: outputs clear at once, nothing until the next sync
    sendFrame(1'b0, -1, 50);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'($urandom % 2));
    sendFrame(1'b1, -1, FL);

    // random traffic: gaps, rare re-syncs, rare guard corruption
    for (int i = 0; i < 3000; i++) begin
      logic st, sy, d;
      st = ($urandom % 10) < 8;
      sy = ($urandom % 150) == 0;
      if (pos >= PL) d = (($urandom % 40) == 0) ? ~GV : GV;
      else           d = 1'($urandom % 2);
      applyStimulus(st, sy, d);
    end

`ifdef GUARD_CHECK_EN
    checkOutput("err_cnt", 32'(dut.u_guard.err_cnt), 32'(expErrCnt));
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
